// File: rtl/exe_stage_pkg.sv
// Shared definitions for the EXE stage: ALU command codes, forwarding
// selects and the MUL/DIV sequencer states.
package exe_stage_pkg;

  typedef enum logic [3:0] {
    CMD_ADD = 4'b0000,
    CMD_SUB = 4'b0010,
    CMD_AND = 4'b0100,
    CMD_OR  = 4'b0101,
    CMD_NOR = 4'b0110,
    CMD_XOR = 4'b0111,
    CMD_SLL = 4'b1000,
    CMD_SRA = 4'b1001,
    CMD_SRL = 4'b1010,
    CMD_MUL = 4'b1100,
    CMD_DIV = 4'b1101
  } exe_cmd_e;

  // Forwarding selects; 2'b11 falls back to the ID/EX value.
  localparam logic [1:0] FWD_IDEX = 2'b00;
  localparam logic [1:0] FWD_MEM  = 2'b01;
  localparam logic [1:0] FWD_WB   = 2'b10;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_RUN  = 2'b01,
    MD_DONE = 2'b10
  } md_state_e;

  typedef enum logic {
    MD_OP_MUL = 1'b0,
    MD_OP_DIV = 1'b1
  } md_op_e;

  function automatic logic is_muldiv(input logic [3:0] cmd);
    return (cmd == CMD_MUL) || (cmd == CMD_DIV);
  endfunction

endpackage

// File: rtl/exe_stage_if.sv
// ID/EX -> EXE -> EX/MEM signal bundle. master = pipeline side driving the
// ID/EX fields and forwarding values, slave = the EXE stage.
interface exe_stage_if #(parameter int WIDTH = 32);
  logic [WIDTH-1:0] PC_in;
  logic [WIDTH-1:0] Val1_in;
  logic [WIDTH-1:0] Val2_in;
  logic [WIDTH-1:0] Reg2_in;
  logic [3:0]       EXE_cmd_in;
  logic             MEM_R_en_in;
  logic             MEM_W_en_in;
  logic             WB_en_in;
  logic [4:0]       dest_in;
  logic [1:0]       sel_src1;
  logic [1:0]       sel_src2;
  logic [1:0]       sel_st;
  logic [WIDTH-1:0] MEM_fwd_val;
  logic [WIDTH-1:0] WB_fwd_val;
  logic [WIDTH-1:0] ALU_result;
  logic [WIDTH-1:0] Br_addr;
  logic [WIDTH-1:0] ST_val;
  logic             MEM_R_en;
  logic             MEM_W_en;
  logic             WB_en;
  logic [4:0]       dest;
  logic             exe_stall;

  modport master (
    output PC_in, Val1_in, Val2_in, Reg2_in, EXE_cmd_in, MEM_R_en_in,
           MEM_W_en_in, WB_en_in, dest_in, sel_src1, sel_src2, sel_st,
           MEM_fwd_val, WB_fwd_val,
    input  ALU_result, Br_addr, ST_val, MEM_R_en, MEM_W_en, WB_en, dest,
           exe_stall
  );

  modport slave (
    input  PC_in, Val1_in, Val2_in, Reg2_in, EXE_cmd_in, MEM_R_en_in,
           MEM_W_en_in, WB_en_in, dest_in, sel_src1, sel_src2, sel_st,
           MEM_fwd_val, WB_fwd_val,
    output ALU_result, Br_addr, ST_val, MEM_R_en, MEM_W_en, WB_en, dest,
           exe_stall
  );
endinterface

// File: rtl/exe_stage_mul_div_iter.sv
// Iterative unsigned MUL (shift-add, low WIDTH bits) / DIV (restoring,
// quotient). One step per cycle, WIDTH steps. Operands are sampled only on
// IDLE->RUN; divide by zero naturally yields an all-ones quotient.
module exe_stage_mul_div_iter
  import exe_stage_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  md_op_e           i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  md_state_e        r_state, w_next;
  md_op_e           r_op;
  logic [CW-1:0]    r_cnt;
  // MUL: r_acc = product, r_x = shifted multiplicand, r_y = shifted multiplier
  // DIV: r_acc = partial remainder, r_x = dividend -> quotient, r_y = divisor
  logic [WIDTH-1:0] r_acc, r_x, r_y;
  logic [WIDTH:0]   w_sh;
  logic             w_ge;
  logic [WIDTH-1:0] w_sub;

  assign w_sh  = {r_acc, r_x[WIDTH-1]};
  assign w_ge  = (w_sh >= {1'b0, r_y});
  // Only used when w_ge, where the difference is below the divisor and fits.
  assign w_sub = w_sh[WIDTH-1:0] - r_y;

  assign o_result = (r_op == MD_OP_DIV) ? r_x : r_acc;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= MD_IDLE;
    else     r_state <= w_next;
  end

  // Next state and busy/done decode
  always_comb begin
    w_next = r_state;
    o_busy = 1'b0;
    o_done = 1'b0;
    case (r_state)
      MD_IDLE: if (i_start) begin
        o_busy = 1'b1;
        w_next = MD_RUN;
      end
      MD_RUN: begin
        o_busy = 1'b1;
        if (r_cnt == LAST) w_next = MD_DONE;
      end
      MD_DONE: begin
        o_done = 1'b1;
        w_next = MD_IDLE;
      end
      default: w_next = MD_IDLE;
    endcase
  end

  // Operand capture on start, then one iteration step per RUN cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op  <= MD_OP_MUL;
      r_cnt <= '0;
      r_acc <= '0;
      r_x   <= '0;
      r_y   <= '0;
    end else if (r_state == MD_IDLE && i_start) begin
      r_op  <= i_op;
      r_cnt <= '0;
      r_acc <= '0;
      r_x   <= i_a;
      r_y   <= i_b;
    end else if (r_state == MD_RUN) begin
      r_cnt <= r_cnt + 1'b1;
      if (r_op == MD_OP_MUL) begin
        if (r_y[0]) r_acc <= r_acc + r_x;
        r_x <= r_x << 1;
        r_y <= r_y >> 1;
      end else begin
        r_acc <= w_ge ? w_sub : w_sh[WIDTH-1:0];
        r_x   <= {r_x[WIDTH-2:0], w_ge};
      end
    end
  end

endmodule

// File: rtl/exe_stage.sv
// MIPS EXE stage: operand forwarding, single-cycle ALU, branch-target adder
// and the iterative MUL/DIV unit. While MUL/DIV runs, exe_stall holds the
// upstream registers and a bubble goes to EX/MEM.
module exe_stage
  import exe_stage_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  exe_stage_if.slave   bus
);
  localparam int SHW = $clog2(WIDTH);

  exe_cmd_e         w_cmd;
  logic [WIDTH-1:0] w_a, w_b, w_alu, w_md_res;
  logic [SHW-1:0]   w_shamt;
  logic             w_md_start, w_md_busy, w_md_done;

  function automatic logic [WIDTH-1:0] fwd(input logic [1:0] sel,
                                           input logic [WIDTH-1:0] idex,
                                           input logic [WIDTH-1:0] mem,
                                           input logic [WIDTH-1:0] wb);
    case (sel)
      FWD_MEM: return mem;
      FWD_WB:  return wb;
      default: return idex;
    endcase
  endfunction

  assign w_cmd   = exe_cmd_e'(bus.EXE_cmd_in);
  assign w_a     = fwd(bus.sel_src1, bus.Val1_in, bus.MEM_fwd_val, bus.WB_fwd_val);
  assign w_b     = fwd(bus.sel_src2, bus.Val2_in, bus.MEM_fwd_val, bus.WB_fwd_val);
  assign w_shamt = w_b[SHW-1:0];

  // Start is masked during reset so the stall drops while rst is held.
  assign w_md_start = is_muldiv(bus.EXE_cmd_in) && !rst;

  exe_stage_mul_div_iter #(.WIDTH(WIDTH)) u_md (
    .clk      (clk),
    .rst      (rst),
    .i_start  (w_md_start),
    .i_op     ((w_cmd == CMD_DIV) ? MD_OP_DIV : MD_OP_MUL),
    .i_a      (w_a),
    .i_b      (w_b),
    .o_busy   (w_md_busy),
    .o_done   (w_md_done),
    .o_result (w_md_res)
  );

  // Single-cycle ALU; MUL/DIV and undefined codes give 0 here
  always_comb begin
    w_alu = '0;
    case (w_cmd)
      CMD_ADD: w_alu = w_a + w_b;
      CMD_SUB: w_alu = w_a - w_b;
      CMD_AND: w_alu = w_a & w_b;
      CMD_OR:  w_alu = w_a | w_b;
      CMD_NOR: w_alu = ~(w_a | w_b);
      CMD_XOR: w_alu = w_a ^ w_b;
      CMD_SLL: w_alu = w_a << w_shamt;
      CMD_SRA: w_alu = $signed(w_a) >>> w_shamt;
      CMD_SRL: w_alu = w_a >> w_shamt;
      default: w_alu = '0;
    endcase
  end

  assign bus.Br_addr   = bus.PC_in + {bus.Val2_in[WIDTH-3:0], 2'b00};
  assign bus.ST_val    = fwd(bus.sel_st, bus.Reg2_in, bus.MEM_fwd_val, bus.WB_fwd_val);
  assign bus.dest      = bus.dest_in;
  assign bus.exe_stall = w_md_busy;

  // Result select and bubble gating of the control bits
  always_comb begin
    bus.ALU_result = w_alu;
    bus.MEM_R_en   = bus.MEM_R_en_in;
    bus.MEM_W_en   = bus.MEM_W_en_in;
    bus.WB_en      = bus.WB_en_in;
    if (w_md_busy) begin
      bus.ALU_result = '0;
      bus.MEM_R_en   = 1'b0;
      bus.MEM_W_en   = 1'b0;
      bus.WB_en      = 1'b0;
    end else if (w_md_done) begin
      bus.ALU_result = w_md_res;
    end
  end

endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage: table of single-cycle vectors plus
// hand-written MUL/DIV, back-to-back and mid-run reset sequences.
module tb_exe_stage;
  logic clk = 1'b0;
  logic rst;
  int   n_pass = 0;
  int   n_tot  = 0;

  always #5 clk = ~clk;

  exe_stage_if #(.WIDTH(32)) bus ();
  exe_stage #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [3:0]  cmd;
    logic [1:0]  s1, s2, sst;
    logic [31:0] v1, v2, r2, mem, wb;
    logic        wben;
    logic [31:0] alu, st, br;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic drive(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b);
    bus.EXE_cmd_in  = cmd;
    bus.Val1_in     = a;
    bus.Val2_in     = b;
    bus.Reg2_in     = 32'h0;
    bus.sel_src1    = 2'b00;
    bus.sel_src2    = 2'b00;
    bus.sel_st      = 2'b00;
    bus.MEM_R_en_in = 1'b1;
    bus.MEM_W_en_in = 1'b1;
    bus.WB_en_in    = 1'b1;
    bus.dest_in     = 5'd9;
  endtask

  // Drives a MUL/DIV and follows it through the stall to the result cycle.
  // Returns sitting in the DONE cycle.
  task automatic run_md(input string nm, input logic [3:0] cmd,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp);
    int n;
    bit bad;
    @(negedge clk);
    drive(cmd, a, b);
    #1;
    n = 0;
    bad = 1'b0;
    while (bus.exe_stall === 1'b1 && n < 100) begin
      if (bus.WB_en !== 1'b0 || bus.MEM_R_en !== 1'b0 || bus.MEM_W_en !== 1'b0 ||
          bus.ALU_result !== 32'h0 || bus.dest !== 5'd9 || bus.Br_addr !== 32'h100 + (b << 2))
        bad = 1'b1;
      n++;
      @(negedge clk);
      #1;
    end
    chk({nm, " stall_cycles"}, 32'(n), 32'd33);
    chk({nm, " bubble"}, 32'(bad), 32'd0);
    chk({nm, " result"}, bus.ALU_result, exp);
    chk({nm, " wb_en"}, 32'(bus.WB_en), 32'd1);
    chk({nm, " mem_w_en"}, 32'(bus.MEM_W_en), 32'd1);
  endtask

  initial begin
    //           cmd     s1 s2 sst  v1            v2            r2     mem  wb  wben alu           st     br
    vecs[0]  = '{4'b0000, 0, 0, 0, 32'd5,        32'd7,        32'hAA, 0,   0,  1, 32'd12,       32'hAA, 32'h11C};
    vecs[1]  = '{4'b0010, 1, 0, 1, 32'd0,        32'd30,       32'h0,  100, 0,  1, 32'd70,       32'd100, 32'h178};
    vecs[2]  = '{4'b0010, 1, 2, 2, 32'd0,        32'd30,       32'h0,  100, 3,  0, 32'd97,       32'd3,  32'h178};
    vecs[3]  = '{4'b1000, 0, 0, 0, 32'd1,        32'd31,       32'h0,  0,   0,  1, 32'h80000000, 32'h0,  32'h17C};
    vecs[4]  = '{4'b1001, 0, 0, 0, 32'h80000000, 32'd4,        32'h0,  0,   0,  1, 32'hF8000000, 32'h0,  32'h110};
    vecs[5]  = '{4'b1010, 0, 0, 0, 32'h80000000, 32'd4,        32'h0,  0,   0,  1, 32'h08000000, 32'h0,  32'h110};
    vecs[6]  = '{4'b0100, 0, 0, 0, 32'hF0F0,     32'hFF00,     32'h0,  0,   0,  1, 32'hF000,     32'h0,  32'h3FD00};
    vecs[7]  = '{4'b0101, 0, 0, 0, 32'hF0F0,     32'h0F0F,     32'h0,  0,   0,  1, 32'hFFFF,     32'h0,  32'h3D3C};
    vecs[8]  = '{4'b0110, 0, 0, 0, 32'h0,        32'h0,        32'h0,  0,   0,  1, 32'hFFFFFFFF, 32'h0,  32'h100};
    vecs[9]  = '{4'b0111, 0, 0, 0, 32'hFF,       32'h0F,       32'h0,  0,   0,  0, 32'hF0,       32'h0,  32'h13C};
    vecs[10] = '{4'b0011, 0, 0, 0, 32'd5,        32'h0,        32'h0,  0,   0,  1, 32'h0,        32'h0,  32'h100};
    vecs[11] = '{4'b0000, 3, 3, 3, 32'd1,        32'd2,        32'h55, 50,  60, 1, 32'd3,        32'h55, 32'h108};
    vecs[12] = '{4'b0000, 0, 0, 0, 32'd0,        32'd3,        32'h0,  0,   0,  1, 32'd3,        32'h0,  32'h10C};
    vecs[13] = '{4'b0000, 0, 0, 0, 32'd0,        32'hC0000001, 32'h0,  0,   0,  1, 32'hC0000001, 32'h0,  32'h104};
    vecs[14] = '{4'b0010, 0, 0, 0, 32'd0,        32'd1,        32'h0,  0,   0,  1, 32'hFFFFFFFF, 32'h0,  32'h104};
    vecs[15] = '{4'b1000, 0, 0, 0, 32'd1,        32'h21,       32'h0,  0,   0,  1, 32'd2,        32'h0,  32'h184};

    // Reset with a MUL pending: stall must stay low while rst is held
    rst = 1'b1;
    bus.PC_in       = 32'h100;
    bus.MEM_fwd_val = 32'h0;
    bus.WB_fwd_val  = 32'h0;
    drive(4'b1100, 32'd2, 32'd3);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("reset stall", 32'(bus.exe_stall), 32'd0);
    chk("reset wb_en", 32'(bus.WB_en), 32'd1);
    rst = 1'b0;
    drive(4'b0000, 32'd0, 32'd0);

    // Single-cycle table
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      bus.EXE_cmd_in  = vecs[i].cmd;
      bus.sel_src1    = vecs[i].s1;
      bus.sel_src2    = vecs[i].s2;
      bus.sel_st      = vecs[i].sst;
      bus.Val1_in     = vecs[i].v1;
      bus.Val2_in     = vecs[i].v2;
      bus.Reg2_in     = vecs[i].r2;
      bus.MEM_fwd_val = vecs[i].mem;
      bus.WB_fwd_val  = vecs[i].wb;
      bus.WB_en_in    = vecs[i].wben;
      bus.PC_in       = 32'h100;
      #1;
      chk($sformatf("vec%0d alu", i), bus.ALU_result, vecs[i].alu);
      chk($sformatf("vec%0d stall", i), 32'(bus.exe_stall), 32'd0);
      chk($sformatf("vec%0d wb_en", i), 32'(bus.WB_en), 32'(vecs[i].wben));
      chk($sformatf("vec%0d st_val", i), bus.ST_val, vecs[i].st);
      chk($sformatf("vec%0d br_addr", i), bus.Br_addr, vecs[i].br);
    end
    bus.MEM_fwd_val = 32'h0;
    bus.WB_fwd_val  = 32'h0;

    // Multi-cycle ops
    run_md("mul1234x5678", 4'b1100, 32'd1234, 32'd5678, 32'd7006652);
    run_md("mul_overflow", 4'b1100, 32'h00010000, 32'h00010000, 32'h0);
    run_md("div100_7", 4'b1101, 32'd100, 32'd7, 32'd14);
    run_md("div5_0", 4'b1101, 32'd5, 32'd0, 32'hFFFFFFFF);

    // Holding the DIV past DONE restarts it one cycle later
    @(negedge clk);
    #1;
    chk("restart stall", 32'(bus.exe_stall), 32'd1);
    chk("restart wb_en", 32'(bus.WB_en), 32'd0);

    // Advance to RUN count 10, then reset mid-run
    for (int k = 0; k < 11; k++) @(negedge clk);
    #1;
    chk("midrun stall", 32'(bus.exe_stall), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("midrun reset stall", 32'(bus.exe_stall), 32'd0);
    chk("midrun reset wb_en", 32'(bus.WB_en), 32'd1);
    rst = 1'b0;
    drive(4'b0000, 32'd4, 32'd6);
    #1;
    chk("post reset add", bus.ALU_result, 32'd10);
    run_md("div9_3", 4'b1101, 32'd9, 32'd3, 32'd3);

    @(negedge clk);
    drive(4'b0000, 32'd0, 32'd0);
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
